// File: rtl/fetch_align_buffer.sv
// Instruction realignment buffer between the fetch port and decode.
// Fetch lines are written into a circular halfword queue; one 16-bit or
// 32-bit instruction per cycle is reassembled from the head of the queue,
// including instructions that straddle a line or the queue wrap point.
//
// Handshakes: both sides use valid/ready. A transfer happens on a rising
// clock edge where valid and ready are both high. The producer holds valid
// and its payload stable until the transfer, except that a flush withdraws
// all offered data. fetch_ready_o depends only on registered state.
module fetch_align_buffer #(
  parameter int FETCH_HW = 2,
  parameter int DEPTH    = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic [31:0]              flush_pc_i,
  input  logic                     fetch_valid_i,
  input  logic [31:0]              fetch_pc_i,
  input  logic [16*FETCH_HW-1:0]   fetch_data_i,
  input  logic                     fetch_error_i,
  output logic                     fetch_ready_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [31:0]              out_pc_o,
  output logic [31:0]              out_instr_o,
  output logic                     out_comp_o,
  output logic                     out_error_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OB = $clog2(FETCH_HW);

  // Halfword storage: {err, pc[31:1], hw}
  logic [15:0]   mem_hw  [DEPTH];
  logic [30:0]   mem_pc  [DEPTH];
  logic          mem_err [DEPTH];

  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [CW-1:0] count;
  logic          first_line;
  logic [OB-1:0] offset;

  logic [PW-1:0] rptr1;
  logic [15:0]   h0_hw;
  logic [15:0]   h1_hw;
  logic [30:0]   h0_pc;
  logic          h0_err;
  logic          h1_err;
  logic          is_comp;
  logic          avail;
  logic          pop;
  logic          wr;
  logic [CW-1:0] pop_n;
  logic [CW-1:0] wr_n;
  logic [PW-1:0] rptr_adv;

  // Address bits below the line base and above the redirect offset carry no
  // information for this block.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{fetch_pc_i[OB:0], flush_pc_i[31:OB+1], flush_pc_i[0]};

  // Room for a whole line; count never exceeds DEPTH so the subtraction cannot wrap.
  assign fetch_ready_o = (CW'(DEPTH) - count) >= CW'(FETCH_HW);
  assign count_o       = count;

  // Decode the queue head into one instruction; data outputs are zero when not valid.
  always_comb begin
    rptr1       = rptr + PW'(1);
    h0_hw       = mem_hw[rptr];
    h0_pc       = mem_pc[rptr];
    h0_err      = mem_err[rptr];
    h1_hw       = mem_hw[rptr1];
    h1_err      = mem_err[rptr1];
    // A faulted halfword is never combined with its neighbour.
    is_comp     = h0_err | (h0_hw[1:0] != 2'b11);
    avail       = is_comp ? (count >= CW'(1)) : (count >= CW'(2));
    out_valid_o = avail & ~flush_i;
    out_pc_o    = 32'h0;
    out_instr_o = 32'h0;
    out_comp_o  = 1'b0;
    out_error_o = 1'b0;
    if (out_valid_o) begin
      out_pc_o    = {h0_pc, 1'b0};
      out_comp_o  = is_comp;
      out_instr_o = is_comp ? {16'h0, h0_hw} : {h1_hw, h0_hw};
      out_error_o = h0_err | (~is_comp & h1_err);
    end
  end

  // Per-cycle transfer amounts for the pointer and count update.
  always_comb begin
    pop      = out_valid_o & out_ready_i;
    pop_n    = is_comp ? CW'(1) : CW'(2);
    wr       = fetch_valid_i & fetch_ready_o & ~flush_i;
    // The first line after a redirect skips the halfwords before the target.
    wr_n     = first_line ? (CW'(FETCH_HW) - CW'(offset)) : CW'(FETCH_HW);
    rptr_adv = '0;
    if (wr && first_line) rptr_adv = rptr_adv + PW'(offset);
    if (pop)              rptr_adv = rptr_adv + PW'(pop_n);
  end

  // Pointer, count and redirect state; reset beats flush beats normal traffic.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rptr       <= '0;
      wptr       <= '0;
      count      <= '0;
      first_line <= 1'b1;
      offset     <= '0;
    end else if (flush_i) begin
      rptr       <= '0;
      wptr       <= '0;
      count      <= '0;
      first_line <= 1'b1;
      offset     <= flush_pc_i[OB:1];
    end else begin
      rptr  <= rptr + rptr_adv;
      count <= count + (wr ? wr_n : CW'(0)) - (pop ? pop_n : CW'(0));
      if (wr) begin
        wptr       <= wptr + PW'(FETCH_HW);
        first_line <= 1'b0;
      end
    end
  end

  // Write a whole line into consecutive entries, wrapping modulo DEPTH.
  always_ff @(posedge clock) begin
    if (reset && wr) begin
      for (int k = 0; k < FETCH_HW; k++) begin
        mem_hw[wptr + PW'(k)]  <= fetch_data_i[16*k +: 16];
        mem_pc[wptr + PW'(k)]  <= {fetch_pc_i[31:OB+1], OB'(k)};
        mem_err[wptr + PW'(k)] <= fetch_error_i;
      end
    end
  end

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Bench for fetch_align_buffer: directed scenarios plus random traffic,
// checked every cycle against a halfword-queue reference model.
module tb_fetch_align_buffer;

  localparam int FETCH_HW = 2;
  localparam int DEPTH    = 8;
  localparam int LW       = 16 * FETCH_HW;
  localparam int CW       = $clog2(DEPTH) + 1;

  logic          clock;
  logic          reset;
  logic          flush_i;
  logic [31:0]   flush_pc_i;
  logic          fetch_valid_i;
  logic [31:0]   fetch_pc_i;
  logic [LW-1:0] fetch_data_i;
  logic          fetch_error_i;
  logic          fetch_ready_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [31:0]   out_pc_o;
  logic [31:0]   out_instr_o;
  logic          out_comp_o;
  logic          out_error_o;
  logic [CW-1:0] count_o;

  fetch_align_buffer #(.FETCH_HW(FETCH_HW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .fetch_valid_i(fetch_valid_i), .fetch_pc_i(fetch_pc_i),
    .fetch_data_i(fetch_data_i), .fetch_error_i(fetch_error_i),
    .fetch_ready_o(fetch_ready_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_pc_o(out_pc_o), .out_instr_o(out_instr_o),
    .out_comp_o(out_comp_o), .out_error_o(out_error_o),
    .count_o(count_o)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the queue holds exactly the halfwords decode has yet to see.
  typedef struct packed {
    logic        err;
    logic [31:0] pc;
    logic [15:0] hw;
  } hw_t;
  hw_t mq[$];
  logic       m_first = 1'b1;
  int         m_off   = 0;

  // Last sampled DUT outputs, for directed checks.
  logic        obs_valid, obs_comp, obs_err, obs_ready;
  logic [31:0] obs_pc, obs_instr;
  logic [CW-1:0] obs_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, compare against the model, then advance the model.
  task automatic step(input logic fl, input logic [31:0] fpc, input logic fv,
                      input logic [31:0] lpc, input logic [LW-1:0] ldata,
                      input logic lerr, input logic rdy);
    logic        e_valid, e_comp, e_err, e_ready;
    logic [31:0] e_pc, e_instr;
    int          npop;
    @(negedge clock);
    flush_i = fl; flush_pc_i = fpc; fetch_valid_i = fv; fetch_pc_i = lpc;
    fetch_data_i = ldata; fetch_error_i = lerr; out_ready_i = rdy;
    #1;
    e_valid = 0; e_comp = 0; e_err = 0; e_pc = 0; e_instr = 0;
    e_ready = (DEPTH - mq.size()) >= FETCH_HW;
    if (!fl && mq.size() >= 1) begin
      if (mq[0].err) begin
        e_valid = 1; e_comp = 1; e_err = 1; e_instr = {16'h0, mq[0].hw};
      end else if (mq[0].hw[1:0] != 2'b11) begin
        e_valid = 1; e_comp = 1; e_instr = {16'h0, mq[0].hw};
      end else if (mq.size() >= 2) begin
        e_valid = 1; e_instr = {mq[1].hw, mq[0].hw}; e_err = mq[1].err;
      end
      if (e_valid) e_pc = mq[0].pc;
    end
    check("valid", 32'(out_valid_o), 32'(e_valid));
    check("pc", out_pc_o, e_pc);
    check("instr", out_instr_o, e_instr);
    check("comp", 32'(out_comp_o), 32'(e_comp));
    check("error", 32'(out_error_o), 32'(e_err));
    check("count", 32'(count_o), 32'(mq.size()));
    check("fetch_ready", 32'(fetch_ready_o), 32'(e_ready));
    obs_valid = out_valid_o; obs_comp = out_comp_o; obs_err = out_error_o;
    obs_ready = fetch_ready_o; obs_pc = out_pc_o; obs_instr = out_instr_o;
    obs_count = count_o;
    if (fl) begin
      mq.delete();
      m_first = 1'b1;
      m_off   = (fpc % (2 * FETCH_HW)) / 2;
    end else begin
      npop = (e_valid && rdy) ? (e_comp ? 1 : 2) : 0;
      for (int i = 0; i < npop; i++) void'(mq.pop_front());
      if (fv && e_ready) begin
        for (int k = (m_first ? m_off : 0); k < FETCH_HW; k++) begin
          hw_t h;
          h.err = lerr;
          h.pc  = (lpc & ~32'(2 * FETCH_HW - 1)) + 32'(2 * k);
          h.hw  = ldata[16*k +: 16];
          mq.push_back(h);
        end
        m_first = 1'b0;
      end
    end
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'h0, 1'b0, 32'h0, '0, 1'b0, rdy);
  endtask

  task automatic push(input logic [31:0] lpc, input logic [LW-1:0] ldata,
                      input logic lerr, input logic rdy);
    step(1'b0, 32'h0, 1'b1, lpc, ldata, lerr, rdy);
  endtask

  task automatic flush(input logic [31:0] fpc);
    step(1'b1, fpc, 1'b0, 32'h0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic found;
    // Reset
    reset = 1'b0; flush_i = 0; flush_pc_i = 0; fetch_valid_i = 0; fetch_pc_i = 0;
    fetch_data_i = '0; fetch_error_i = 0; out_ready_i = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_valid", 32'(out_valid_o), 32'h0);
    check("rst_pc", out_pc_o, 32'h0);
    check("rst_instr", out_instr_o, 32'h0);
    check("rst_count", 32'(count_o), 32'h0);
    check("rst_fetch_ready", 32'(fetch_ready_o), 32'h1);
    reset = 1'b1;

    // Aligned 32-bit instruction
    flush(32'h1000);
    push(32'h1000, 32'h00A00513, 1'b0, 1'b0);
    idle(1'b1);
    check("t1_valid", 32'(obs_valid), 32'h1);
    check("t1_instr", obs_instr, 32'h00A00513);
    check("t1_comp", 32'(obs_comp), 32'h0);
    idle(1'b0);
    check("t1_count", 32'(obs_count), 32'h0);

    // Two compressed instructions in one line
    push(32'h1000, 32'h40014505, 1'b0, 1'b1);
    idle(1'b1);
    check("t2_pc0", obs_pc, 32'h1000);
    check("t2_instr0", obs_instr, 32'h00004505);
    idle(1'b1);
    check("t2_pc1", obs_pc, 32'h1002);
    check("t2_instr1", obs_instr, 32'h00004001);

    // Mid-line redirect and a 32-bit instruction straddling two lines
    flush(32'h1006);
    push(32'h1004, 32'h05131234, 1'b0, 1'b0);
    idle(1'b0);
    check("t3_wait_valid", 32'(obs_valid), 32'h0);
    check("t3_wait_count", 32'(obs_count), 32'h1);
    push(32'h1008, 32'hAAAA00A0, 1'b0, 1'b0);
    idle(1'b1);
    check("t3_pc", obs_pc, 32'h1006);
    check("t3_instr", obs_instr, 32'h00A00513);
    idle(1'b1);
    check("t3_pc2", obs_pc, 32'h100A);
    check("t3_instr2", obs_instr, 32'h0000AAAA);

    // Full queue and fetch backpressure
    flush(32'h2000);
    for (int i = 0; i < 4; i++) push(32'h2000 + 32'(4 * i), 32'h45054505, 1'b0, 1'b0);
    idle(1'b0);
    check("t4_full_count", 32'(obs_count), 32'd8);
    check("t4_full_ready", 32'(obs_ready), 32'h0);
    idle(1'b1);
    idle(1'b1);
    check("t4_count7", 32'(obs_count), 32'd7);
    check("t4_ready7", 32'(obs_ready), 32'h0);
    idle(1'b0);
    check("t4_count6", 32'(obs_count), 32'd6);
    check("t4_ready6", 32'(obs_ready), 32'h1);

    // Faulted line
    flush(32'h3000);
    push(32'h3000, 32'h00000513, 1'b1, 1'b0);
    idle(1'b0);
    check("t5_valid", 32'(obs_valid), 32'h1);
    check("t5_err", 32'(obs_err), 32'h1);
    check("t5_comp", 32'(obs_comp), 32'h1);
    idle(1'b1);
    idle(1'b0);
    check("t5_count", 32'(obs_count), 32'h1);

    // Flush colliding with write and pop
    flush(32'h4000);
    push(32'h4000, 32'h45054505, 1'b0, 1'b0);
    push(32'h4004, 32'h45054505, 1'b0, 1'b0);
    idle(1'b0);
    check("t6_count", 32'(obs_count), 32'd4);
    step(1'b1, 32'h4000, 1'b1, 32'h4008, 32'h45054505, 1'b0, 1'b1);
    check("t6_valid", 32'(obs_valid), 32'h0);
    idle(1'b0);
    check("t6_count0", 32'(obs_count), 32'h0);

    // 32-bit instruction straddling queue index DEPTH-1 and 0
    flush(32'h1002);
    push(32'h1000, 32'h00011234, 1'b0, 1'b1);
    push(32'h1004, 32'h45054505, 1'b0, 1'b1);
    push(32'h1008, 32'h45054505, 1'b0, 1'b1);
    push(32'h100C, 32'h05134505, 1'b0, 1'b1);
    push(32'h1010, 32'h450500A0, 1'b0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      idle(1'b1);
      if (obs_valid && obs_pc == 32'h100E) begin
        found = 1'b1;
        check("t7_instr", obs_instr, 32'h00A00513);
        check("t7_comp", 32'(obs_comp), 32'h0);
      end
    end
    check("t7_found", 32'(found), 32'h1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [LW-1:0] d;
      for (int k = 0; k < FETCH_HW; k++) begin
        d[16*k +: 16] = 16'($urandom());
        if ($urandom_range(1, 0) == 1) d[16*k +: 2] = 2'b11;
      end
      step($urandom_range(99, 0) < 3, $urandom(), $urandom_range(99, 0) < 60,
           $urandom(), d, $urandom_range(99, 0) < 5, $urandom_range(99, 0) < 70);
    end
    idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_align_buffer.md
Name: fetch_align_buffer

Overview:
Parametrised instruction realignment buffer that sits between the fetch port and decode.
- Accepts fetch lines of FETCH_HW halfwords and stores them in a circular halfword queue.
- Reassembles 16-bit compressed and 32-bit instructions that may straddle line or wrap boundaries.
- Presents one instruction per cycle to decode over a valid/ready handshake.
- Versus the previous generation, it adds configurable line width and depth, true decode backpressure, per-halfword error tagging and arbitrary-halfword redirect offsets.

Parameters:
FETCH_HW, 2, halfwords per fetch line; power of 2, 2 or 4.
DEPTH, 8, halfword entries in the queue; power of 2, minimum 2*FETCH_HW.

Ports:
clock  input  1  clock
reset  input  1  synchronous reset, active-low
flush_i  input  1  redirect; discards all buffered and in-flight data
flush_pc_i  input  32  redirect target; halfword offset within its line selects the first valid halfword
fetch_valid_i  input  1  fetch line present
fetch_pc_i  input  32  line address; low log2(FETCH_HW)+1 bits ignored
fetch_data_i  input  16*FETCH_HW  line data; halfword 0 in bits 15:0
fetch_error_i  input  1  access fault for the whole line
fetch_ready_o  output  1  buffer can accept a full line
out_valid_o  output  1  instruction available
out_ready_i  input  1  decode accepts
out_pc_o  output  32  instruction pc
out_instr_o  output  32  instruction; compressed zero-extended
out_comp_o  output  1  instruction is 16-bit
out_error_o  output  1  fault on any constituent halfword
count_o  output  $clog2(DEPTH)+1  halfwords held

Behaviour:
Storage and pointers
- Each entry holds {err, pc[31:1], hw[15:0]}.
- rptr and wptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
- count is $clog2(DEPTH)+1 bits.
Reset (reset==0 at posedge)
- rptr=wptr=count=0; first-line flag=1; align offset=0.
- Outputs after reset: out_valid_o=0, out_pc_o=0, out_instr_o=0, out_comp_o=0, out_error_o=0, count_o=0, fetch_ready_o=1.
- Reset overrides flush and all other activity.
fetch_ready_o
- fetch_ready_o = (DEPTH - count) >= FETCH_HW.
- Driven from registered state only; no combinational path from out_ready_i.
Write
- Occurs when fetch_valid_i & fetch_ready_o & ~flush_i.
- Writes FETCH_HW entries at wptr..wptr+FETCH_HW-1 (mod DEPTH).
- Entry k gets pc = {fetch_pc_i line base, k}, err = fetch_error_i.
- wptr += FETCH_HW.
- If the first-line flag is set: rptr += offset, count += FETCH_HW - offset, flag cleared. Otherwise count += FETCH_HW.
- Written data is visible at the output the next cycle; there is no same-cycle bypass.
Output (combinational from registered state)
- h0 = entry[rptr]; h1 = entry[rptr+1 mod DEPTH].
- If h0.err=1: out_valid_o = count>=1; treated as one halfword; out_comp_o=1; out_error_o=1.
- Else if h0.hw[1:0]!=2'b11: compressed. Valid when count>=1; out_instr_o={16'h0,h0.hw}.
- Else: 32-bit. Valid when count>=2; out_instr_o={h1.hw,h0.hw}; out_error_o=h1.err.
- out_pc_o = {h0.pc,1'b0}.
- While out_valid_o=0, all data outputs are 0.
- While flush_i=1, out_valid_o is forced to 0.
Pop
- Occurs when out_valid_o & out_ready_i.
- rptr and count advance by 1 (compressed or error) or 2 (32-bit).
- Simultaneous write and pop: count = count + written - popped in the same cycle.
- Outputs are held stable while out_valid_o=1 and out_ready_i=0, except when flush_i is asserted.
Flush
- Takes effect at the next edge: rptr=wptr=count=0, first-line flag=1.
- Offset = flush_pc_i[log2(FETCH_HW):1].
- Any write or pop presented in the flush cycle is ignored.
- A flush arriving while the first-line flag is already set only updates the offset.
Invariants
- count never exceeds DEPTH and never goes negative.
- A 32-bit instruction whose second halfword is not yet written holds out_valid_o=0 and does not deadlock.
- A straddle across the DEPTH-1→0 index is read correctly.

Test Plan:
1. FETCH_HW=2, DEPTH=8. Reset, flush_pc 0x1000, line pc 0x1000 data 0x00A00513 → next cycle out_valid=1, pc 0x1000, instr 0x00A00513, comp=0; after pop count_o=0.
2. Line 0x1000 data 0x40014505, out_ready=1 → two cycles: (0x1000, 0x00004505, comp=1), then (0x1002, 0x00004001, comp=1).
3. flush_pc 0x1006; line 0x1004 data 0x05131234 → out_valid=0, count_o=1. Line 0x1008 data 0xAAAA00A0 → pc 0x1006, instr 0x00A00513. Remaining hw 0xAAAA has bits 1:0=10 (compressed) → next pc 0x100A, instr 0x0000AAAA.
4. out_ready=0, push four lines → count_o=8, fetch_ready_o=0. Pop one compressed → count_o=7, fetch_ready_o still 0. Pop another → count_o=6, fetch_ready_o=1.
5. Line with fetch_error_i=1, hw0=0x0513 → out_valid=1, error=1, comp=1; pop consumes 1 halfword.
6. count_o=4 with flush_i=1, fetch_valid_i=1 and out_ready_i=1 in the same cycle → out_valid=0 that cycle; next cycle count_o=0, no pop counted.
7. Fill so that a 32-bit instruction's halfwords sit at index 7 and index 0 → correct {h1,h0} assembly and pc.
